mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Parametrised MEM stage for the 5-stage MIPS pipeline. It is the successor of the word-only data access block.
- Owns an internal synchronous data RAM of configurable depth.
- Supports byte, halfword and word loads and stores, with sign/zero extension and byte-lane write enables.
- Detects misaligned accesses and suppresses them.
- Holds the MEM/WB pipeline register with stall support.
- Sits between the EX/MEM register and the write-back mux; branch_out feeds PC select.

Parameters:
B, 32, datapath/address width; only 32 is legal (4 byte lanes).
W, 5, register-file address width.
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold MEM/WB register and inhibit RAM write
addr_in  in  B  ALU result / byte address
write_data  in  B  store data (rt)
mem_write  in  1  store request
mem_read  in  1  load request
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned  in  1  1 = zero-extend loads (LBU/LHU)
zero  in  1  ALU zero flag
branch_in  in  1  branch instruction
reg_write_in  in  1  write-back enable
write_reg_in  in  W  destination register
mem_to_reg_in  in  1  WB select
data_out  out  B  registered load result, extended
alu_out  out  B  registered addr_in
write_reg_out  out  W  registered write_reg_in
reg_write_out  out  1  registered, gated by misalignment
mem_to_reg_out  out  1  registered mem_to_reg_in
branch_out  out  1  combinational zero & branch_in
misaligned_out  out  1  registered alignment fault flag

Behaviour:
- Addressing:
  - Word index = addr_in[DEPTH_LOG2+1:2].
  - Upper address bits are ignored, so accesses wrap modulo 4*2^DEPTH_LOG2 bytes.
  - Little-endian lanes: byte offset 0 maps to bits 7:0.
- Alignment:
  - Half requires addr_in[0]=0; word requires addr_in[1:0]=00; bytes are always aligned.
  - Misaligned access (mem_read|mem_write): no RAM write, data_out=0, reg_write_out=0, misaligned_out=1 for that result cycle.
- Store:
  - Byte enables: SB sets 1 lane at offset; SH sets lanes {1,0} or {3,2}; SW sets all 4.
  - Write data is replicated to all lanes (byte x4, half x2).
  - Write commits on the rising edge when mem_write=1, aligned, stall=0 and reset=0.
- Load:
  - RAM read is synchronous.
  - Lane is selected by registered addr_in[1:0] and mem_size.
  - Sign-extended unless mem_unsigned=1.
- Latency:
  - Inputs sampled at edge N; all registered outputs valid after edge N (one cycle).
  - A load at edge N+1 to an address stored at edge N returns the new data (write-first, no bypass needed across cycles).
- Same-cycle priority: mem_write and mem_read both 1 is treated as a store only; data_out=0.
- No memory op (mem_read=0): data_out=0.
- Stall:
  - All registered outputs hold previous values.
  - No RAM write occurs.
  - Inputs are ignored; the upstream stage re-presents them.
- Reset:
  - All registered outputs are cleared to 0, including misaligned_out.
  - Any write in that cycle is suppressed.
  - RAM contents are not cleared.
  - Reset has priority over stall.
  - Asserting reset mid-sequence discards the in-flight result.
- branch_out is purely combinational and unaffected by stall or reset.
- mem_size=11 behaves identically to 10.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → data_out=0xDEADBEEF one cycle later; reg_write_out=1.
- SB 0x7F @0x21 over word 0, then LB @0x21 → 0x0000007F. Then SB 0x80 @0x22 and LB @0x22 → 0xFFFFFF80, LBU @0x22 → 0x00000080; LW @0x20 → 0x00807F00.
- SH 0x8001 @0x32, then LH @0x32 → 0xFFFF8001, LHU → 0x00008001; the low half of word @0x30 is unchanged.
- Misaligned cases:
  - SW @0x41 → misaligned_out=1, reg_write_out=0, word @0x40 unchanged.
  - LH @0x43 → misaligned_out=1, data_out=0.
- Stall and reset:
  - Hold stall=1 for 3 cycles during SW 0x12345678 @0x50 → outputs frozen, memory unchanged. Release and re-present → LW returns 0x12345678.
  - reset=1 with stall=1 → all outputs 0.
- Wrap and branch:
  - With DEPTH_LOG2=10, SW 0xA5A5A5A5 @0x1000, then LW @0x0 → 0xA5A5A5A5.
  - zero=1, branch_in=1 → branch_out=1 in the same cycle; zero=0 → branch_out=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: sub-word loads/stores into an internal
// synchronous data RAM, misalignment suppression and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int B          = 32,
  parameter int W          = 5,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [B-1:0] addr_in,
  input  logic [B-1:0] write_data,
  input  logic         mem_write,
  input  logic         mem_read,
  input  logic [1:0]   mem_size,
  input  logic         mem_unsigned,
  input  logic         zero,
  input  logic         branch_in,
  input  logic         reg_write_in,
  input  logic [W-1:0] write_reg_in,
  input  logic         mem_to_reg_in,
  output logic [B-1:0] data_out,
  output logic [B-1:0] alu_out,
  output logic [W-1:0] write_reg_out,
  output logic         reg_write_out,
  output logic         mem_to_reg_out,
  output logic         branch_out,
  output logic         misaligned_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Select and extend the addressed lane of a fetched RAM word.
  function automatic logic [B-1:0] load_extend(input logic [B-1:0] word,
                                               input logic [1:0]   off,
                                               input logic [1:0]   size,
                                               input logic         uns);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = word[8*off +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = {{24{byte_v[7] & ~uns}}, byte_v};
      2'b01:   load_extend = {{16{half_v[15] & ~uns}}, half_v};
      default: load_extend = word;
    endcase
  endfunction

  logic [B-1:0]          ram [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  mis_s;
  logic [3:0]            be_s;
  logic [B-1:0]          wdata_s;
  logic                  we_s;

  logic [B-1:0]          rdata_r;
  logic [1:0]            off_r;
  logic [1:0]            size_r;
  logic                  uns_r;
  logic                  load_r;
  logic [B-1:0]          alu_r;
  logic [W-1:0]          write_reg_r;
  logic                  reg_write_r;
  logic                  mem_to_reg_r;
  logic                  mis_r;

  assign idx_s = addr_in[DEPTH_LOG2+1:2];

  // Alignment check, byte-lane enables and lane-replicated store data.
  always_comb begin
    mis_s   = 1'b0;
    be_s    = 4'b0000;
    wdata_s = write_data;
    case (mem_size)
      2'b00: begin
        be_s    = 4'b0001 << addr_in[1:0];
        wdata_s = {4{write_data[7:0]}};
      end
      2'b01: begin
        mis_s   = addr_in[0];
        be_s    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{write_data[15:0]}};
      end
      default: begin
        mis_s   = (addr_in[1:0] != 2'b00);
        be_s    = 4'b1111;
        wdata_s = write_data;
      end
    endcase
    if (mem_read || mem_write) begin
      mis_s = mis_s;
    end else begin
      mis_s = 1'b0;
    end
    we_s = mem_write & ~mis_s & ~stall & ~reset;
  end

  // Byte-lane RAM write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_s && be_s[i]) begin
        ram[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
      end
    end
  end

  // Synchronous RAM read; a stalled cycle keeps the previous word.
  always_ff @(posedge clk) begin
    if (!stall) begin
      rdata_r <= ram[idx_s];
    end
  end

  // MEM/WB pipeline register; reset outranks stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      off_r        <= 2'b00;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      load_r       <= 1'b0;
      alu_r        <= '0;
      write_reg_r  <= '0;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mis_r        <= 1'b0;
    end else if (!stall) begin
      off_r        <= addr_in[1:0];
      size_r       <= mem_size;
      uns_r        <= mem_unsigned;
      load_r       <= mem_read & ~mem_write & ~mis_s;
      alu_r        <= addr_in;
      write_reg_r  <= write_reg_in;
      reg_write_r  <= reg_write_in & ~mis_s;
      mem_to_reg_r <= mem_to_reg_in;
      mis_r        <= mis_s;
    end
  end

  // Load result is zero unless the registered op was an aligned load.
  always_comb begin
    data_out = '0;
    if (load_r) begin
      data_out = load_extend(rdata_r, off_r, size_r, uns_r);
    end else begin
      data_out = '0;
    end
  end

  assign alu_out        = alu_r;
  assign write_reg_out  = write_reg_r;
  assign reg_write_out  = reg_write_r;
  assign mem_to_reg_out = mem_to_reg_r;
  assign misaligned_out = mis_r;
  assign branch_out     = zero & branch_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: byte-addressed memory model plus literal spot checks.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0;
  logic [31:0] addr_in = 32'd0, write_data = 32'd0;
  logic        mem_write = 1'b0, mem_read = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'b10;
  logic        zero = 1'b0, branch_in = 1'b0, reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
  logic [4:0]  write_reg_in = 5'd0;
  logic [31:0] data_out, alu_out;
  logic [4:0]  write_reg_out;
  logic        reg_write_out, mem_to_reg_out, branch_out, misaligned_out;

  mem_access_stage #(.B(32), .W(5), .DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .addr_in(addr_in), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .zero(zero), .branch_in(branch_in),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in), .mem_to_reg_in(mem_to_reg_in),
    .data_out(data_out), .alu_out(alu_out), .write_reg_out(write_reg_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .branch_out(branch_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: 4 KiB byte array, addresses taken modulo its size.
  logic [7:0]  mm [0:4095];
  logic [31:0] e_data = 32'd0, e_alu = 32'd0;
  logic [4:0]  e_wr = 5'd0;
  logic        e_rw = 1'b0, e_mtr = 1'b0, e_mis = 1'b0;

  initial for (int i = 0; i < 4096; i++) mm[i] = 8'h00;

  always @(posedge clk) begin
    int a;
    int nbytes;
    logic mis;
    logic [31:0] v;
    a = int'(addr_in[11:0]);
    nbytes = (mem_size == 2'b00) ? 1 : (mem_size == 2'b01) ? 2 : 4;
    mis = (mem_read | mem_write) && ((a % nbytes) != 0);
    if (reset) begin
      e_data = 0; e_alu = 0; e_wr = 0; e_rw = 0; e_mtr = 0; e_mis = 0;
    end else if (!stall) begin
      e_alu = addr_in; e_wr = write_reg_in; e_mtr = mem_to_reg_in;
      e_rw = reg_write_in & ~mis; e_mis = mis;
      e_data = 0;
      if (mem_read && !mem_write && !mis) begin
        v = 0;
        for (int k = 0; k < nbytes; k++) v = v | (32'(mm[(a + k) % 4096]) << (8 * k));
        if (!mem_unsigned && nbytes == 1 && v[7])  v = v - 32'h100;
        if (!mem_unsigned && nbytes == 2 && v[15]) v = v - 32'h10000;
        e_data = v;
      end
      if (mem_write && !mis)
        for (int k = 0; k < nbytes; k++) mm[(a + k) % 4096] = write_data[8*k +: 8];
    end
  end

  // Compare process: every cycle once the first reset has been applied.
  always @(negedge clk) begin
    if (checking) begin
      chk("data_out", data_out, e_data);
      chk("alu_out", alu_out, e_alu);
      chk("write_reg_out", 32'(write_reg_out), 32'(e_wr));
      chk("reg_write_out", 32'(reg_write_out), 32'(e_rw));
      chk("mem_to_reg_out", 32'(mem_to_reg_out), 32'(e_mtr));
      chk("misaligned_out", 32'(misaligned_out), 32'(e_mis));
      chk("branch_out", 32'(branch_out), 32'(zero & branch_in));
    end
  end

  // Present one operation for one clock, then return at the following negedge.
  task automatic op(input logic w, input logic r, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    mem_write = w; mem_read = r; mem_size = sz; mem_unsigned = uns;
    addr_in = a; write_data = d; write_reg_in = rd;
    reg_write_in = r | (rd != 5'd0); mem_to_reg_in = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    checking = 1'b1;
    chk("reset data_out", data_out, 32'h0);
    chk("reset reg_write_out", 32'(reg_write_out), 32'h0);
    reset = 1'b0;

    op(1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd0);
    op(1, 0, 2'b10, 0, 32'h30, 32'h0, 5'd0);
    op(1, 0, 2'b10, 0, 32'h40, 32'h11223344, 5'd0);
    op(1, 0, 2'b10, 0, 32'h50, 32'h0, 5'd0);

    op(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0);
    op(0, 1, 2'b10, 0, 32'h10, 32'h0, 5'd3);
    chk("lw 0x10", data_out, 32'hDEADBEEF);
    chk("lw rw", 32'(reg_write_out), 32'h1);
    op(0, 1, 2'b11, 0, 32'h10, 32'h0, 5'd3);
    chk("lw size11", data_out, 32'hDEADBEEF);

    op(1, 0, 2'b00, 0, 32'h21, 32'h7F, 5'd0);
    op(0, 1, 2'b00, 0, 32'h21, 32'h0, 5'd4);
    chk("lb 0x21", data_out, 32'h0000007F);
    op(1, 0, 2'b00, 0, 32'h22, 32'h80, 5'd0);
    op(0, 1, 2'b00, 0, 32'h22, 32'h0, 5'd4);
    chk("lb 0x22", data_out, 32'hFFFFFF80);
    op(0, 1, 2'b00, 1, 32'h22, 32'h0, 5'd4);
    chk("lbu 0x22", data_out, 32'h00000080);
    op(0, 1, 2'b10, 0, 32'h20, 32'h0, 5'd4);
    chk("lw 0x20", data_out, 32'h00807F00);

    op(1, 0, 2'b01, 0, 32'h32, 32'h8001, 5'd0);
    op(0, 1, 2'b01, 0, 32'h32, 32'h0, 5'd5);
    chk("lh 0x32", data_out, 32'hFFFF8001);
    op(0, 1, 2'b01, 1, 32'h32, 32'h0, 5'd5);
    chk("lhu 0x32", data_out, 32'h00008001);
    op(0, 1, 2'b10, 0, 32'h30, 32'h0, 5'd5);
    chk("lw 0x30", data_out, 32'h80010000);

    op(1, 0, 2'b10, 0, 32'h41, 32'hCAFEF00D, 5'd6);
    chk("sw mis flag", 32'(misaligned_out), 32'h1);
    chk("sw mis rw", 32'(reg_write_out), 32'h0);
    op(0, 1, 2'b10, 0, 32'h40, 32'h0, 5'd6);
    chk("lw 0x40 intact", data_out, 32'h11223344);
    op(0, 1, 2'b01, 0, 32'h43, 32'h0, 5'd7);
    chk("lh mis flag", 32'(misaligned_out), 32'h1);
    chk("lh mis data", data_out, 32'h0);
    op(1, 1, 2'b10, 0, 32'h60, 32'h55, 5'd0);
    chk("st+ld data", data_out, 32'h0);

    op(0, 1, 2'b10, 0, 32'h40, 32'h0, 5'd8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 2'b10, 0, 32'h50, 32'h12345678, 5'd9);
      chk("stall hold data", data_out, 32'h11223344);
      chk("stall hold wr", 32'(write_reg_out), 32'd8);
    end
    stall = 1'b0;
    op(0, 1, 2'b10, 0, 32'h50, 32'h0, 5'd9);
    chk("stall no write", data_out, 32'h0);
    op(1, 0, 2'b10, 0, 32'h50, 32'h12345678, 5'd0);
    op(0, 1, 2'b10, 0, 32'h50, 32'h0, 5'd9);
    chk("lw 0x50", data_out, 32'h12345678);

    reset = 1'b1; stall = 1'b1;
    op(1, 0, 2'b10, 0, 32'h50, 32'hFFFFFFFF, 5'd9);
    chk("rst+stall data", data_out, 32'h0);
    chk("rst+stall alu", alu_out, 32'h0);
    reset = 1'b0; stall = 1'b0;
    op(0, 1, 2'b10, 0, 32'h50, 32'h0, 5'd9);
    chk("rst no write", data_out, 32'h12345678);

    op(1, 0, 2'b10, 0, 32'h1000, 32'hA5A5A5A5, 5'd0);
    op(0, 1, 2'b10, 0, 32'h0, 32'h0, 5'd10);
    chk("wrap lw 0x0", data_out, 32'hA5A5A5A5);

    zero = 1'b1; branch_in = 1'b1; #1;
    chk("branch taken", 32'(branch_out), 32'h1);
    zero = 1'b0; #1;
    chk("branch not", 32'(branch_out), 32'h0);
    op(0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0);
    branch_in = 1'b0;
    op(0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
